// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: run/step/load/mode requests in, LFSR state and status pulses out.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             run;
    logic             step;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] lfsr_out;
    logic             tick;
    logic             adv;
    logic [WIDTH-1:0] period;
    logic             wrap;
    logic             lockup;

    modport master (
        output run, step, mode, load, seed_in,
        input  lfsr_out, tick, adv, period, wrap, lockup
    );

    modport slave (
        input  run, step, mode, load, seed_in,
        output lfsr_out, tick, adv, period, wrap, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci/Galois LFSR with seed load, clock-enable divider, period counter and lock-up flag.
// Define LFSR_LOCKUP_RECOVER_EN to replace zero loads / all-zero states with SEED.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter logic [WIDTH-1:0] SEED  = 'h01,
    parameter int unsigned      DIV   = 25_000_000
) (
    input logic         clk50mhz,
    input logic         rst,
    lfsr_gen_if.slave   bus
);

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    localparam int             DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [WIDTH-1:0] state_q, ref_val_q, period_q;
    logic             adv_q, wrap_q, lockup_q;
    logic [DIV_W-1:0] div_q, div_d;

    logic             tick_c, adv_c, zero_c;
    logic [WIDTH-1:0] fib_c, gal_c, nxt_c, load_val_c;

    always_comb begin
        tick_c = bus.run && (div_q == DIV_LAST);
        if (!bus.run || tick_c) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        adv_c  = tick_c || bus.step;
        zero_c = (state_q == '0);
        fib_c  = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        gal_c  = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        nxt_c  = bus.mode ? gal_c : fib_c;
        // An all-zero state is a fixed point of both structures; recovery jumps back to SEED.
        if (RECOVER && zero_c) begin
            nxt_c = SEED;
        end

        load_val_c = bus.seed_in;
        if (RECOVER && (bus.seed_in == '0)) begin
            load_val_c = SEED;
        end
    end

    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            state_q   <= SEED;
            ref_val_q <= SEED;
            period_q  <= '0;
            adv_q     <= 1'b0;
            wrap_q    <= 1'b0;
            lockup_q  <= 1'b0;
            div_q     <= '0;
        end else begin
            div_q  <= div_d;
            adv_q  <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.load) begin
                state_q   <= load_val_c;
                ref_val_q <= load_val_c;
                period_q  <= '0;
                lockup_q  <= 1'b0;
            end else if (adv_c) begin
                state_q <= nxt_c;
                adv_q   <= 1'b1;
                if (zero_c) begin
                    lockup_q <= 1'b1;
                end
                if (nxt_c == ref_val_q) begin
                    wrap_q   <= 1'b1;
                    period_q <= '0;
                end else if (RECOVER && zero_c) begin
                    period_q <= '0;
                end else if (period_q != '1) begin
                    period_q <= period_q + WIDTH'(1);
                end
            end
        end
    end

    assign bus.lfsr_out = state_q;
    assign bus.tick     = tick_c;
    assign bus.adv      = adv_q;
    assign bus.period   = period_q;
    assign bus.wrap     = wrap_q;
    assign bus.lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen (WIDTH=8, TAPS=B8, SEED=01, DIV=4).
module tb_lfsr_gen;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lfsr_gen_if #(.WIDTH(W)) bus ();

    lfsr_gen #(
        .WIDTH(W),
        .TAPS (8'hB8),
        .SEED (8'h01),
        .DIV  (4)
    ) dut (
        .clk50mhz(clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m);
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.load    = 1'b0;
        bus.mode    = m;
        bus.seed_in = '0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_fib [4];
        logic [7:0] exp_gal [5];
        int         n, early, cycles;
        logic [7:0] pb;

        exp_fib = '{8'h02, 8'h04, 8'h08, 8'h11};
        exp_gal = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

        // Reset values
        do_reset(1'b0);
        chk("rst_lfsr",   32'(bus.lfsr_out), 32'h01);
        chk("rst_tick",   32'(bus.tick),     32'h0);
        chk("rst_adv",    32'(bus.adv),      32'h0);
        chk("rst_period", 32'(bus.period),   32'h0);
        chk("rst_wrap",   32'(bus.wrap),     32'h0);
        chk("rst_lockup", 32'(bus.lockup),   32'h0);

        // Fibonacci stepping
        for (int i = 0; i < 4; i++) begin
            bus.step = 1'b1;
            cyc();
            chk($sformatf("fib_step%0d", i), 32'(bus.lfsr_out), 32'(exp_fib[i]));
            chk($sformatf("fib_adv%0d", i),  32'(bus.adv),      32'h1);
            bus.step = 1'b0;
            cyc();
            chk($sformatf("fib_adv_lo%0d", i), 32'(bus.adv), 32'h0);
        end
        chk("fib_period", 32'(bus.period), 32'd4);

        // Galois stepping
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.step = 1'b1;
            cyc();
            chk($sformatf("gal_step%0d", i), 32'(bus.lfsr_out), 32'(exp_gal[i]));
            bus.step = 1'b0;
            cyc();
            chk($sformatf("gal_adv_lo%0d", i), 32'(bus.adv), 32'h0);
        end

        // Divider: run for 12 cycles
        do_reset(1'b0);
        bus.run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("run_tick%0d", k), 32'(bus.tick), 32'((k % 4) == 3));
            chk($sformatf("run_adv%0d", k),  32'(bus.adv),  32'((k % 4) == 0));
        end
        chk("run_lfsr",   32'(bus.lfsr_out), 32'h08);
        chk("run_period", 32'(bus.period),   32'd3);
        bus.run = 1'b0;
        cyc();
        chk("idle_tick0", 32'(bus.tick), 32'h0);
        cyc();
        chk("idle_tick1", 32'(bus.tick), 32'h0);
        chk("idle_adv",   32'(bus.adv),  32'h0);
        // Counter must restart from 0: first tick on the 3rd edge after run rises
        bus.run = 1'b1;
        cyc();
        cyc();
        chk("restart_tick_lo", 32'(bus.tick), 32'h0);
        cyc();
        chk("restart_tick_hi", 32'(bus.tick), 32'h1);
        bus.step = 1'b1;
        cyc();
        chk("coinc_lfsr", 32'(bus.lfsr_out), 32'h11);
        chk("coinc_adv",  32'(bus.adv),      32'h1);
        bus.step = 1'b0;
        bus.run  = 1'b0;
        cyc();
        chk("coinc_once", 32'(bus.lfsr_out), 32'h11);
        chk("coinc_adv_lo", 32'(bus.adv),    32'h0);

        // Load during a tick cycle
        do_reset(1'b0);
        bus.run = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("load_tick", 32'(bus.tick), 32'h1);
        bus.load    = 1'b1;
        bus.seed_in = 8'h5A;
        cyc();
        bus.load = 1'b0;
        chk("load_lfsr",   32'(bus.lfsr_out), 32'h5A);
        chk("load_adv",    32'(bus.adv),      32'h0);
        chk("load_period", 32'(bus.period),   32'h0);
        cyc();
        cyc();
        cyc();
        chk("load_tick2", 32'(bus.tick), 32'h1);
        cyc();
        chk("load_next",   32'(bus.lfsr_out), 32'hB4);
        chk("load_adv2",   32'(bus.adv),      32'h1);
        chk("load_period2", 32'(bus.period),  32'd1);
        bus.run = 1'b0;

        // Full-period wrap in each mode
        for (int m = 0; m < 2; m++) begin
            do_reset(1'(m));
            bus.run = 1'b1;
            n      = 0;
            early  = 0;
            cycles = 0;
            pb     = '0;
            while (n < 255 && cycles < 3000) begin
                pb = bus.period;
                cyc();
                cycles++;
                if (bus.adv) begin
                    n++;
                    if (n < 255 && bus.wrap) early++;
                end
            end
            chk($sformatf("wrap_count_m%0d", m),  32'(n),            32'd255);
            chk($sformatf("wrap_pulse_m%0d", m),  32'(bus.wrap),     32'h1);
            chk($sformatf("wrap_lfsr_m%0d", m),   32'(bus.lfsr_out), 32'h01);
            chk($sformatf("wrap_period_m%0d", m), 32'(bus.period),   32'h0);
            chk($sformatf("wrap_before_m%0d", m), 32'(pb),           32'd254);
            chk($sformatf("wrap_early_m%0d", m),  32'(early),        32'd0);
            cyc();
            chk($sformatf("wrap_lo_m%0d", m), 32'(bus.wrap), 32'h0);
            bus.run = 1'b0;
        end

        // Zero load and lock-up
        do_reset(1'b0);
        bus.load    = 1'b1;
        bus.seed_in = 8'h00;
        cyc();
        bus.load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("zload_lfsr",   32'(bus.lfsr_out), 32'h01);
        chk("zload_lockup", 32'(bus.lockup),   32'h0);
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        chk("zstep_lfsr",   32'(bus.lfsr_out), 32'h02);
        chk("zstep_adv",    32'(bus.adv),      32'h1);
        chk("zstep_lockup", 32'(bus.lockup),   32'h0);
`else
        chk("zload_lfsr",   32'(bus.lfsr_out), 32'h00);
        chk("zload_lockup", 32'(bus.lockup),   32'h0);
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        chk("zstep_lfsr",   32'(bus.lfsr_out), 32'h00);
        chk("zstep_adv",    32'(bus.adv),      32'h1);
        chk("zstep_lockup", 32'(bus.lockup),   32'h1);
        cyc();
        chk("zsticky_lockup", 32'(bus.lockup), 32'h1);
        bus.load    = 1'b1;
        bus.seed_in = 8'h5A;
        cyc();
        bus.load = 1'b0;
        chk("zclear_lockup", 32'(bus.lockup),   32'h0);
        chk("zclear_lfsr",   32'(bus.lfsr_out), 32'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator: a WIDTH-bit LFSR with selectable Fibonacci/Galois structure, programmable taps, seed load, and an internal clock-enable divider. It can also single-step from a pushbutton. It feeds the seven-segment display path and test-pattern consumers on the 50 MHz board clock, and reports sequence period and lock-up status.

## Interface
- WIDTH, 8, LFSR width in bits (3..32)
- TAPS, 8'hB8, feedback tap mask, WIDTH bits; bit i set = stage i taps feedback
- SEED, 8'h01, reset/recovery state; must be non-zero
- DIV, 25_000_000, clk50mhz cycles per automatic advance (>= 1)

Ports:
- clk50mhz  input  1  system clock, 50 MHz
- rst  input  1  asynchronous reset, active-high
- run  input  1  1 = free-run at divider rate; 0 = divider held at 0
- step  input  1  single-cycle pulse: advance once (synchronous, pre-debounced)
- mode  input  1  0 = Fibonacci, 1 = Galois
- load  input  1  single-cycle pulse: state <= seed_in
- seed_in  input  WIDTH  value taken on load
- lfsr_out  output  WIDTH  current LFSR state
- tick  output  1  one-cycle pulse when the divider expires
- adv  output  1  one-cycle pulse in the cycle the state advanced
- period  output  WIDTH  advances since the last load/reset/wrap (saturating counter)
- wrap  output  1  one-cycle pulse when the state returns to the last loaded value
- lockup  output  1  sticky: all-zero state detected; cleared by rst or load

## Operation
- Fibonacci next state: {q[WIDTH-2:0], ^(q & TAPS)}.
- Galois next state: q[0] ? ((q >> 1) ^ TAPS) : (q >> 1).
- Advance condition: (run & tick) | step. When both are true in the same cycle, the state advances exactly once.
- Priority, highest first: rst, load, advance. A load cycle never advances and never pulses adv.
- Divider: counter runs 0..DIV-1 while run=1. tick is asserted in the cycle where the counter equals DIV-1; the counter then returns to 0. When run=0 the counter is held at 0 and tick=0.
- Reference register: captures SEED on reset and seed_in on load.
- wrap: asserted on an advance whose next state equals the reference. In that same cycle, period is reset to 0.
- period: incremented by 1 on every other advance. It saturates at all-ones; it does not wrap.
- mode may change at any time. The new structure applies from the next advance and the state is not reset.
- Lock-up: a state of all zeros with any advance condition sets lockup.

## Timing
- Reset values: lfsr_out=SEED, tick=0, adv=0, period=0, wrap=0, lockup=0; divider=0; reference=SEED.
- Latency from advance condition to new lfsr_out is 1 cycle. adv and wrap are registered and coincide with the new lfsr_out.
- Load: lfsr_out=seed_in, period=0, and lockup=0 on the next edge.
- Free-run period is DIV cycles between tick pulses. The first tick comes DIV cycles after run rises.
- rst asserted mid-operation clears everything immediately and asynchronously. Deassertion is synchronised externally.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined:
  - A load with seed_in==0 loads SEED instead.
  - An all-zero state is replaced by SEED on the next advance condition. That advance pulses adv, sets lockup, and resets period to 0.
- Undefined:
  - A zero load is accepted as-is.
  - An all-zero state stays at zero on every advance; adv still pulses.
  - lockup is set and no recovery occurs.

## Test plan
Common configuration for all scenarios: WIDTH=8, TAPS=8'hB8, SEED=8'h01, DIV=4.
- Reset, mode=0, step pulses ×4 -> lfsr_out 02, 04, 08, 11, with adv high for one cycle per step.
- Reset, mode=1, step ×5 -> lfsr_out B8, 5C, 2E, 17, B3.
- run=1 held for 12 cycles -> tick every 4th cycle, 3 advances, no tick when run=0; step coincident with tick -> single advance.
- Free-run in each mode for 255 advances -> wrap pulses on the 255th advance, period reads 254 the cycle before and 0 after.
- load seed_in=8'h5A during a tick cycle -> lfsr_out=5A, no advance, period=0; next advance follows from 5A.
- load seed_in=0 then step:
  - With LFSR_LOCKUP_RECOVER_EN: state 01 after the load, with normal stepping.
  - Without: state stays 00 and lockup=1 after the step.
